// File: rtl/btn_debounce_pkg.sv
// Shared constants and width helpers for the push-button debouncer.
// Edge strobes are built only when BTN_DEBOUNCE_EDGE_EN is defined.
package btn_debounce_pkg;

  localparam int BTN_TICK_DIV_DEFAULT     = 50000;
  localparam int BTN_STABLE_TICKS_DEFAULT = 8;

  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  function automatic int div_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, tick-gated stability counter,
// level register and (with BTN_DEBOUNCE_EDGE_EN) registered edge strobes.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = BTN_STABLE_TICKS_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = tick_i && (sync != level_o) && (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_i;
      sync <= meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      level_o <= 1'b0;
    end else if (tick_i) begin
      if (sync == level_o) begin
        cnt <= '0;
      end else if (accept) begin
        cnt     <= '0;
        level_o <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BTN_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= accept && sync;
      fall_o <= accept && !sync;
    end
  end
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: shared sample prescaler plus one
// btn_debounce_chan per pin. Strobes gated by BTN_DEBOUNCE_EDGE_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = BTN_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = BTN_STABLE_TICKS_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             tick_o
);

  localparam int PW = div_width(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  // Channels update on the same edge that raises tick_o.
  assign tick = (pcnt == PLAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt   <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= tick;
      pcnt   <= tick ? '0 : pcnt + PW'(1);
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_i (tick),
      .btn_i  (btn_i[n]),
      .level_o(level_o[n]),
      .rise_o (rise_o[n]),
      .fall_o (fall_o[n])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing, all
// checked against a cycle-indexed behavioural model (TICK_DIV=4, STABLE=3).
module tb_btn_debounce;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] btn = '0;
  logic [W-1:0] level, rise, fall;
  logic         tick;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int           e;
  logic [W-1:0] pipe1, pipe2;
  logic [W-1:0] m_level, m_rise, m_fall;
  logic         m_tick;
  int           run[W];

  btn_debounce #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_i  (btn),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall),
    .tick_o (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_clear();
    e       = 0;
    pipe1   = '0;
    pipe2   = '0;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_tick  = 1'b0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // One clock edge: model the spec rules, then compare all outputs.
  task automatic cycle();
    logic [W-1:0] b;
    logic         t;
    b = btn;
    @(posedge clk);
    t      = (e % TD) == TD - 1;
    m_rise = '0;
    m_fall = '0;
    if (t) begin
      for (int i = 0; i < W; i++) begin
        if (pipe2[i] == m_level[i]) run[i] = 0;
        else run[i]++;
        if (run[i] == ST) begin
          run[i]     = 0;
          m_level[i] = pipe2[i];
`ifdef BTN_DEBOUNCE_EDGE_EN
          if (pipe2[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
`endif
        end
      end
    end
    m_tick = t;
    pipe2  = pipe1;
    pipe1  = b;
    e++;
    #1;
    check("level", 32'(level), 32'(m_level));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("tick", 32'(tick), 32'(m_tick));
    check("rise_and_fall", 32'(rise & fall), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_fall", 32'(fall), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // held press on channel 0, set before edge 0
    btn[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (e - 1 == 11) begin
        check("s1_level0_e11", 32'(level[0]), 32'd1);
`ifdef BTN_DEBOUNCE_EDGE_EN
        check("s1_rise0_e11", 32'(rise[0]), 32'd1);
`else
        check("s1_rise0_e11", 32'(rise[0]), 32'd0);
`endif
      end
      if (e - 1 == 10) check("s1_level0_e10", 32'(level[0]), 32'd0);
    end

    // channel 1 bounces every 5 cycles for 40 cycles
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) btn[1] = ~btn[1];
      cycle();
    end
    btn[1] = 1'b0;
    run_cycles(20);
    check("s2_level1", 32'(level[1]), 32'd0);

    // channel 2: rise, then drop and hold
    btn[2] = 1'b1;
    run_cycles(16);
    check("s3_level2_hi", 32'(level[2]), 32'd1);
    btn[2] = 1'b0;
    run_cycles(16);
    check("s3_level2_lo", 32'(level[2]), 32'd0);

    // all four rise together
    btn = '0;
    do_reset();
    btn = 4'b1111;
    run_cycles(16);
    check("s4_level_all", 32'(level), 32'hf);

    // reset while channel 0 has two mismatching ticks counted
    btn = '0;
    do_reset();
    btn[0] = 1'b1;
    run_cycles(8);
    do_reset();
    run_cycles(16);
    check("s5_level0", 32'(level[0]), 32'd1);

    // random bouncing with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 24) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
